// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The state encoding is visible on the arbiter's debug port.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping from N-1 to 0.
module uart_rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // The subtraction wraps explicitly, so N need not be a power of two.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams, granting
// whole packets in round-robin order.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CLK_RATE = 100 * 10**6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           tx_data,
    input  logic                        tx_done,
    output logic                        busy,
    output state_t                      state
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CLK_RATE <= 0) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and CLK_RATE positive");
    end

    state_t              state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                last_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                tx_start_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_any;

    logic                accept;
    logic [PTR_W-1:0]    acc_idx;
    logic [BYTE_W-1:0]   acc_data;
    logic                acc_last;
    logic [PTR_W-1:0]    next_ptr;
    logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

    uart_rr_arb #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // Handshake: a byte moves when req_valid[i] and req_ready[i] are both
    // high on a rising edge. req_ready is a one-cycle combinational pulse
    // raised only in an accepting cycle; the requester must hold valid,
    // data and last stable until it sees that pulse.
    always_comb begin
        accept  = 1'b0;
        acc_idx = owner_q;
        case (state_q)
            ST_IDLE: begin
                accept  = arb_any;
                acc_idx = arb_idx;
            end
            ST_WAIT: accept = tx_done && !last_q && req_valid[owner_q];
            ST_HOLD: accept = req_valid[owner_q];
            default: accept = 1'b0;
        endcase
    end

    assign acc_data = req_bytes[acc_idx];
    assign acc_last = req_last[acc_idx];
    assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[acc_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q <= arb_gnt;
                        owner_q <= arb_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_done) begin
                        if (last_q) begin
                            grant_q  <= '0;
                            rr_ptr_q <= next_ptr;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else if (accept) begin
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        state_q <= ST_START;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Every acceptance leads into exactly one ST_START cycle.
            if (accept) begin
                tx_data_q  <= acc_data;
                last_q     <= acc_last;
                tx_start_q <= 1'b1;
            end
        end
    end

    assign grant    = grant_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with three requesters: queued byte sources,
// an auto-responding transmitter model and an in-order byte scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N        = 3;
    localparam int CLK_RATE = 100_000_000;

    typedef struct packed {
        logic [1:0] req;
        logic [7:0] gap;
        logic       last;
        logic [7:0] data;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    state_t         dut_state;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   epoch = 0;
    int   tx_delay = 2;
    int   acc_cnt [N];
    int   acc_on_done = 0;
    int   last_acc_cyc = -10;
    bit   tx_busy_m = 1'b0;
    bit   prev_start = 1'b0;
    ent_t src_q[$];
    logic [9:0] exp_q[$];

    uart_tx_arbiter #(
        .NUM_REQ  (N),
        .CLK_RATE (CLK_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .state     (dut_state)
    );

    // clock and cycle counter
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] g);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic add_src(input int r, input int gap, input bit last, input int d);
        ent_t e;
        e.req  = 2'(r);
        e.gap  = 8'(gap);
        e.last = last;
        e.data = 8'(d);
        src_q.push_back(e);
    endtask

    task automatic add_exp(input int r, input int d);
        exp_q.push_back({2'(r), 8'(d)});
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        epoch++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int n = 0;
        while (dut_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dut_state), 32'(s));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || tx_busy_m || dut_state != ST_IDLE)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() + src_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(dut_state), 32'(ST_IDLE));
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_start"}, 32'(tx_start), 32'd0);
        check({tag, "_data"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dut_state), 32'(ST_IDLE));
    endtask

    // requester driver: pops a byte once its ready pulse was seen
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    for (int j = 0; j < src_q.size(); j++) begin
                        if (src_q[j].req == 2'(i)) begin
                            src_q.delete(j);
                            break;
                        end
                    end
                end
            end
            req_valid = '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < src_q.size(); j++) begin
                    if (src_q[j].req == 2'(i)) begin
                        if (src_q[j].gap != 8'd0) begin
                            src_q[j].gap = src_q[j].gap - 8'd1;
                        end else begin
                            req_valid[i]        = 1'b1;
                            req_last[i]         = src_q[j].last;
                            req_data[8*i +: 8]  = src_q[j].data;
                        end
                        break;
                    end
                end
            end
        end
    end

    // transmitter model: answers each start with a done pulse
    initial begin
        logic [7:0] d;
        int ep;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                d = tx_data;
                ep = epoch;
                tx_busy_m = 1'b1;
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(negedge clk);
                if (ep == epoch) check("tx_data_stable", 32'(tx_data), 32'(d));
                @(posedge clk);
                #1 tx_done = 1'b0;
                tx_busy_m = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_start) begin
                    check("start_gap", 32'(prev_start), 32'd0);
                    check("start_latency", 32'(cyc - last_acc_cyc), 32'd1);
                    check("grant_onehot", 32'($onehot(grant)), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", {22'd0, 2'(oh2idx(grant)), tx_data}, {22'd0, e});
                    end
                end
                if (req_ready != '0) begin
                    check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                    for (int i = 0; i < N; i++) begin
                        if (req_ready[i]) acc_cnt[i]++;
                    end
                    if (tx_done) acc_on_done++;
                    last_acc_cyc = cyc;
                end
                prev_start = tx_start;
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;

        // reset with a request already pending: no acceptance allowed
        rst_n = 1'b0;
        add_src(0, 0, 1, 'h41);
        add_exp(0, 'h41);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single byte
        wait_drain(200, "single");
        check("single_accepts", 32'(acc_cnt[0]), 32'd1);

        // contention from reset: 0,1,0,1
        apply_reset();
        add_src(0, 0, 1, 'hA0);
        add_src(1, 0, 1, 'hB0);
        add_src(0, 0, 1, 'hA1);
        add_src(1, 0, 1, 'hB1);
        add_exp(0, 'hA0);
        add_exp(1, 'hB0);
        add_exp(0, 'hA1);
        add_exp(1, 'hB1);
        wait_drain(400, "contention");

        // packet lock with back-to-back bytes (rr_ptr is 2 here, wraps to 0)
        base = acc_on_done;
        add_src(0, 0, 0, 'h10);
        add_src(0, 0, 0, 'h11);
        add_src(0, 0, 1, 'h12);
        add_src(1, 0, 1, 'h13);
        add_exp(0, 'h10);
        add_exp(0, 'h11);
        add_exp(0, 'h12);
        add_exp(1, 'h13);
        wait_drain(400, "lock");
        check("b2b_accepts", 32'(acc_on_done - base), 32'd2);

        // hold: requester 0 pauses 50 cycles mid-packet while 1 waits
        base = acc_cnt[1];
        add_src(0, 0, 0, 'h20);
        add_src(0, 50, 1, 'h21);
        add_src(1, 0, 1, 'h30);
        add_exp(0, 'h20);
        add_exp(0, 'h21);
        add_exp(1, 'h30);
        wait_state(ST_HOLD, 100, "hold_enter");
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_grant", 32'(grant), 32'b001);
        repeat (30) @(negedge clk);
        check("hold_stays", 32'(dut_state), 32'(ST_HOLD));
        check("hold_no_ready1", 32'(acc_cnt[1] - base), 32'd0);
        wait_drain(400, "hold");

        // all three at once with rr_ptr=2: 2, then wrap to 0, then 1
        add_src(0, 0, 1, 'h40);
        add_src(1, 0, 1, 'h41);
        add_src(2, 0, 1, 'h42);
        add_exp(2, 'h42);
        add_exp(0, 'h40);
        add_exp(1, 'h41);
        wait_drain(400, "wrap");

        // reset while waiting for the transmitter
        tx_delay = 20;
        add_src(1, 0, 0, 'h50);
        add_src(1, 0, 1, 'h51);
        add_exp(1, 'h50);
        wait_state(ST_WAIT, 100, "rst_wait_enter");
        @(posedge clk);
        #3 rst_n = 1'b0;
        src_q.delete();
        epoch++;
        #1;
        check_all_zero("rst_in_wait");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = 0;
        while (tx_busy_m && base < 100) begin
            @(negedge clk);
            base++;
        end
        check("spurious_done_sent", 32'(tx_busy_m), 32'd0);
        @(negedge clk);
        check("spurious_state", 32'(dut_state), 32'(ST_IDLE));
        check("spurious_busy", 32'(busy), 32'd0);

        // arbitration restarts from requester 0
        tx_delay = 2;
        add_src(2, 0, 1, 'h62);
        add_src(0, 0, 1, 'h60);
        add_exp(0, 'h60);
        add_exp(2, 'h62);
        wait_drain(400, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
